sprite_blitter: RTL

//  Upstream feeder of the SRAM frame-buffer controller. Accepts sprite draw commands (screen origin, size, sprite-ROM base),

---
 rtl/sprite_blitter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: pops draw commands, walks each sprite row-major through a synchronous ROM and
// presents one pixel at a time to the frame-buffer controller's write slots.
module sprite_blitter #(
  parameter int unsigned SPRITE_AW   = 12,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480
) (
  input  logic                 sram_clk,
  input  logic                 reset_n,
  input  logic                 frame_clk,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [9:0]           cmd_x,
  input  logic [9:0]           cmd_y,
  input  logic [6:0]           cmd_w,
  input  logic [6:0]           cmd_h,
  input  logic [SPRITE_AW-1:0] cmd_base,
  output logic [SPRITE_AW-1:0] rom_addr,
  input  logic [15:0]          rom_data,
  input  logic                 wr_slot,
  output logic [9:0]           program_x,
  output logic [9:0]           program_y,
  output logic [15:0]          program_data,
  output logic                 busy,
  output logic                 frame_overrun
);

  localparam int unsigned PW = $clog2(CMD_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [9:0]  PARK_X = 10'd1023;
  localparam logic [9:0]  PARK_Y = 10'd511;

  typedef struct packed {
    logic [9:0]           x;
    logic [9:0]           y;
    logic [6:0]           w;
    logic [6:0]           h;
    logic [SPRITE_AW-1:0] base;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, WAIT} state_t;

  state_t               state, state_next;
  cmd_t                 mem [CMD_DEPTH];
  cmd_t                 head;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop, fifo_empty;
  logic [2:0]           frame_sync;
  logic                 frame_pulse;
  logic [9:0]           x0, y0;
  logic [6:0]           w, h, col, row;
  logic [SPRITE_AW-1:0] ptr;
  logic [10:0]          sx, sy;
  logic                 last_pixel;

  // frame_clk is asynchronous: two flops to resynchronise, a third for edge detection
  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) frame_sync <= '0;
    else          frame_sync <= {frame_sync[1:0], frame_clk};
  end
  assign frame_pulse = frame_sync[1] & ~frame_sync[2];

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != CW'(CMD_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !fifo_empty && !frame_pulse;
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;
  assign rom_addr   = ptr;

  always_ff @(posedge sram_clk) begin
    if (push) mem[wr_ptr] <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, base: cmd_base};
  end

  // A flush keeps only a command pushed in the same cycle
  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (frame_pulse) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr_ptr + PW'(push);
      count  <= CW'(push);
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  assign sx         = {1'b0, x0} + {4'b0, col};
  assign sy         = {1'b0, y0} + {4'b0, row};
  assign last_pixel = (row == h - 7'd1) && (col == w - 7'd1);

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (frame_pulse) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (!fifo_empty && head.w != '0 && head.h != '0) state_next = FETCH;
        FETCH:   state_next = LATCH;
        LATCH:   state_next = WAIT;
        WAIT:    if (wr_slot) state_next = last_pixel ? IDLE : FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      x0           <= '0;
      y0           <= '0;
      w            <= '0;
      h            <= '0;
      col          <= '0;
      row          <= '0;
      ptr          <= '0;
      program_x    <= PARK_X;
      program_y    <= PARK_Y;
      program_data <= '0;
    end else if (frame_pulse) begin
      program_x    <= PARK_X;
      program_y    <= PARK_Y;
      program_data <= '0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) begin
          x0  <= head.x;
          y0  <= head.y;
          w   <= head.w;
          h   <= head.h;
          ptr <= head.base;
          col <= '0;
          row <= '0;
        end
        LATCH: begin
          // transparent or clipped pixels still occupy a slot, so they go to the park address
          if (rom_data == TRANSPARENT || sx >= 11'(SCREEN_W) || sy >= 11'(SCREEN_H)) begin
            program_x    <= PARK_X;
            program_y    <= PARK_Y;
            program_data <= '0;
          end else begin
            program_x    <= sx[9:0];
            program_y    <= sy[9:0];
            program_data <= rom_data;
          end
        end
        WAIT: if (wr_slot) begin
          ptr <= ptr + SPRITE_AW'(1);
          if (col == w - 7'd1) begin
            col <= '0;
            row <= row + 7'd1;
          end else begin
            col <= col + 7'd1;
          end
          if (last_pixel) begin
            program_x    <= PARK_X;
            program_y    <= PARK_Y;
            program_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n)                 frame_overrun <= 1'b0;
    else if (frame_pulse && busy) frame_overrun <= 1'b1;
  end

endmodule
